// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational alu: register file, operand drive, result writeback and response handshake.
// Optional completed-response counter (op_count) enabled by defining ALU_ISSUE_OPCOUNT_EN.
module alu_issue_ctrl #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [15:0]      instr,
  input  logic             load_en,
  input  logic [2:0]       load_addr,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_code,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  input  logic             alu_zero,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_carry,
  output logic             resp_zero
`ifdef ALU_ISSUE_OPCOUNT_EN
  ,
  output logic [15:0]      op_count
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [2:0]       op_q;
  logic [2:0]       rd_q;
  logic [2:0]       rs_q;
  logic [2:0]       rt_q;
  logic [WIDTH-1:0] rf_reg [NREGS];
  logic [NREGS-1:0] wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             accept;
  logic             instr_unused;

  assign instr_unused = ^instr[3:0];

  assign instr_ready = (state_reg == IDLE) && !load_en;
  assign accept      = instr_valid && instr_ready;
  assign resp_valid  = (state_reg == RESP);

  // Operands track the register file live, so reads always precede the writeback edge.
  assign alu_a    = rf_reg[rs_q];
  assign alu_b    = rf_reg[rt_q];
  assign alu_code = op_q;

  // Loads and writebacks live in different states, so they never collide.
  assign wr_data = (state_reg == ISSUE) ? alu_out : load_data;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_wr_en
      if (gi == 0) begin : g_r0
        assign wr_en[gi] = 1'b0;
      end else begin : g_rn
        assign wr_en[gi] = ((state_reg == IDLE) && load_en && (load_addr == 3'(gi))) ||
                           ((state_reg == ISSUE) && (rd_q == 3'(gi)));
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wr_en[i]) begin
          rf_reg[i] <= wr_data;
        end
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      resp_data  <= '0;
      resp_carry <= 1'b0;
      resp_zero  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_q <= instr[15:13];
        rd_q <= instr[12:10];
        rs_q <= instr[9:7];
        rt_q <= instr[6:4];
      end
      if (state_reg == ISSUE) begin
        resp_data  <= alu_out;
        resp_carry <= alu_carry;
        resp_zero  <= alu_zero;
      end
    end
  end

`ifdef ALU_ISSUE_OPCOUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      op_count <= '0;
    end else if (resp_valid && resp_ready && (op_count != 16'hFFFF)) begin
      op_count <= op_count + 16'd1;
    end
  end
`endif

endmodule
